// File: rtl/reg_write_sequencer_if.sv
// rtl/reg_write_sequencer_if.sv - request/status bundle for the register write sequencer
interface reg_write_sequencer_if #(
    parameter int SELECTION = 3,
    parameter int NREGS     = 7,
    parameter int LENW      = 3
);
    logic [SELECTION-1:0] sSelDeco;
    logic                 sWrReq;
    logic                 sBurstReq;
    logic [LENW-1:0]      sBurstLen;
    logic [NREGS-1:0]     sProtMask;
    logic [NREGS-1:0]     sOutDeco;
    logic [SELECTION-1:0] sCurSel;
    logic                 sBusy;
    logic                 sDone;
    logic                 sErr;

    modport master (
        output sSelDeco, sWrReq, sBurstReq, sBurstLen, sProtMask,
        input  sOutDeco, sCurSel, sBusy, sDone, sErr
    );

    modport slave (
        input  sSelDeco, sWrReq, sBurstReq, sBurstLen, sProtMask,
        output sOutDeco, sCurSel, sBusy, sDone, sErr
    );
endinterface

// File: rtl/reg_write_sequencer.sv
// rtl/reg_write_sequencer.sv - registered active-low one-hot register write enables, single and burst
module reg_write_sequencer #(
    parameter int SELECTION = 3,
    parameter int NREGS     = 7,
    parameter int LENW      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_write_sequencer_if.slave  bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t               state;
    logic [SELECTION-1:0] idx;
    logic [LENW-1:0]      rem;

    function automatic logic in_range(input logic [SELECTION-1:0] s);
        return int'(s) < NREGS;
    endfunction

    function automatic logic [NREGS-1:0] bit_of(input logic [SELECTION-1:0] s);
        return NREGS'(1) << s;
    endfunction

    function automatic logic is_prot(input logic [SELECTION-1:0] s, input logic [NREGS-1:0] m);
        return |(bit_of(s) & m);
    endfunction

    // A protected slot still occupies its cycle but drives no enable.
    function automatic logic [NREGS-1:0] deco(input logic [SELECTION-1:0] s, input logic [NREGS-1:0] m);
        return is_prot(s, m) ? '1 : ~bit_of(s);
    endfunction

    // Wrap skips the unused codes NREGS..2**SELECTION-1.
    function automatic logic [SELECTION-1:0] next_idx(input logic [SELECTION-1:0] s);
        return (int'(s) == NREGS - 1) ? '0 : s + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            rem          <= '0;
            bus.sOutDeco <= '1;
            bus.sCurSel  <= '0;
            bus.sBusy    <= 1'b0;
            bus.sDone    <= 1'b0;
            bus.sErr     <= 1'b0;
        end else begin
            bus.sOutDeco <= '1;
            bus.sBusy    <= 1'b0;
            bus.sDone    <= 1'b0;
            bus.sErr     <= 1'b0;
            case (state)
                IDLE: begin
                    // sBusy high here means the displayed cycle is a burst's last slot.
                    if (bus.sBusy && (bus.sWrReq || bus.sBurstReq)) begin
                        bus.sErr <= 1'b1;
                    end else if (bus.sBurstReq) begin
                        if (in_range(bus.sSelDeco)) begin
                            bus.sOutDeco <= deco(bus.sSelDeco, bus.sProtMask);
                            bus.sCurSel  <= bus.sSelDeco;
                            bus.sBusy    <= 1'b1;
                            bus.sErr     <= is_prot(bus.sSelDeco, bus.sProtMask);
                            if (bus.sBurstLen == '0) begin
                                bus.sDone <= 1'b1;
                            end else begin
                                idx   <= next_idx(bus.sSelDeco);
                                rem   <= bus.sBurstLen - 1'b1;
                                state <= BURST;
                            end
                        end else begin
                            bus.sErr <= 1'b1;
                        end
                    end else if (bus.sWrReq) begin
                        if (in_range(bus.sSelDeco)) begin
                            bus.sOutDeco <= deco(bus.sSelDeco, bus.sProtMask);
                            bus.sCurSel  <= bus.sSelDeco;
                            bus.sDone    <= 1'b1;
                            bus.sErr     <= is_prot(bus.sSelDeco, bus.sProtMask);
                        end else begin
                            bus.sErr <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    bus.sOutDeco <= deco(idx, bus.sProtMask);
                    bus.sCurSel  <= idx;
                    bus.sBusy    <= 1'b1;
                    bus.sErr     <= is_prot(idx, bus.sProtMask) || bus.sWrReq || bus.sBurstReq;
                    if (rem == '0) begin
                        bus.sDone <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        rem <= rem - 1'b1;
                        idx <= next_idx(idx);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_write_sequencer.sv
// tb/tb_reg_write_sequencer.sv - directed vector bench for reg_write_sequencer
module tb_reg_write_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_write_sequencer_if #(.SELECTION(3), .NREGS(7), .LENW(3)) bus ();

    reg_write_sequencer #(.SELECTION(3), .NREGS(7), .LENW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic       br;
        logic [2:0] sel;
        logic [2:0] len;
        logic [6:0] prot;
        logic [6:0] eout;
        logic [2:0] ecur;
        logic       ebusy;
        logic       edone;
        logic       eerr;
    } vec_t;

    vec_t tv[$];
    int   applied = 0;
    int   errors  = 0;

    function automatic vec_t mk(input logic rst, input logic wr, input logic br,
                                input logic [2:0] sel, input logic [2:0] len, input logic [6:0] prot,
                                input logic [6:0] eout, input logic [2:0] ecur,
                                input logic ebusy, input logic edone, input logic eerr);
        vec_t v;
        v.rst = rst; v.wr = wr; v.br = br; v.sel = sel; v.len = len; v.prot = prot;
        v.eout = eout; v.ecur = ecur; v.ebusy = ebusy; v.edone = edone; v.eerr = eerr;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        reset         = v.rst;
        bus.sWrReq    = v.wr;
        bus.sBurstReq = v.br;
        bus.sSelDeco  = v.sel;
        bus.sBurstLen = v.len;
        bus.sProtMask = v.prot;
        @(posedge clk);
        #1;
        applied++;
        if (bus.sOutDeco !== v.eout) begin
            errors++;
            $display("FAIL %s out: got %b want %b", name, bus.sOutDeco, v.eout);
        end
        if (bus.sCurSel !== v.ecur) begin
            errors++;
            $display("FAIL %s cursel: got %0d want %0d", name, bus.sCurSel, v.ecur);
        end
        if (bus.sBusy !== v.ebusy) begin
            errors++;
            $display("FAIL %s busy: got %b want %b", name, bus.sBusy, v.ebusy);
        end
        if (bus.sDone !== v.edone) begin
            errors++;
            $display("FAIL %s done: got %b want %b", name, bus.sDone, v.edone);
        end
        if (bus.sErr !== v.eerr) begin
            errors++;
            $display("FAIL %s err: got %b want %b", name, bus.sErr, v.eerr);
        end
    endtask

    localparam logic [6:0] NONE = 7'b1111111;

    initial begin
        //             rst wr  br  sel   len   prot        eout        cur   bsy dn  err
        tv.push_back(mk(1, 0, 0, 3'd0, 3'd0, 7'b0000000, NONE,       3'd0, 0, 0, 0)); // reset
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, NONE,       3'd0, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 3'd2, 3'd0, 7'b0000000, 7'b1111011, 3'd2, 0, 1, 0)); // single R2
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, NONE,       3'd2, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 3'd5, 3'd3, 7'b0000000, 7'b1011111, 3'd5, 1, 0, 0)); // burst 5,6,0,1
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, 7'b0111111, 3'd6, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, 7'b1111110, 3'd0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, 7'b1111101, 3'd1, 1, 1, 0));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, NONE,       3'd1, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 3'd6, 3'd1, 7'b0000001, 7'b0111111, 3'd6, 1, 0, 0)); // protected R0
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000001, NONE,       3'd0, 1, 1, 1));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, NONE,       3'd0, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 3'd7, 3'd0, 7'b0000000, NONE,       3'd0, 0, 0, 1)); // out of range
        tv.push_back(mk(0, 0, 1, 3'd7, 3'd2, 7'b0000000, NONE,       3'd0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, NONE,       3'd0, 0, 0, 0));
        tv.push_back(mk(0, 1, 1, 3'd3, 3'd0, 7'b0000000, 7'b1110111, 3'd3, 1, 1, 0)); // burst wins
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, NONE,       3'd3, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 3'd6, 3'd0, 7'b0000000, 7'b0111111, 3'd6, 0, 1, 0)); // top register
        tv.push_back(mk(0, 1, 0, 3'd0, 3'd0, 7'b0000000, 7'b1111110, 3'd0, 0, 1, 0)); // back-to-back
        tv.push_back(mk(0, 0, 1, 3'd6, 3'd7, 7'b0000000, 7'b0111111, 3'd6, 1, 0, 0)); // 8 writes, revisits R6
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, 7'b1111110, 3'd0, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, 7'b1111101, 3'd1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, 7'b1111011, 3'd2, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, 7'b1110111, 3'd3, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, 7'b1101111, 3'd4, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, 7'b1011111, 3'd5, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, 7'b0111111, 3'd6, 1, 1, 0));
        tv.push_back(mk(0, 1, 0, 3'd1, 3'd0, 7'b0000000, NONE,       3'd6, 0, 0, 1)); // req during last slot
        tv.push_back(mk(0, 0, 0, 3'd0, 3'd0, 7'b0000000, NONE,       3'd6, 0, 0, 0));

        foreach (tv[i]) step(tv[i], $sformatf("vec%0d", i));

        // Collision: burst request during the 2nd slot of a running burst.
        step(mk(0, 0, 1, 3'd0, 3'd4, 7'b0, 7'b1111110, 3'd0, 1, 0, 0), "col_r0");
        step(mk(0, 0, 0, 3'd0, 3'd0, 7'b0, 7'b1111101, 3'd1, 1, 0, 0), "col_r1");
        step(mk(0, 0, 1, 3'd5, 3'd1, 7'b0, 7'b1111011, 3'd2, 1, 0, 1), "col_r2");
        step(mk(0, 0, 0, 3'd0, 3'd0, 7'b0, 7'b1110111, 3'd3, 1, 0, 0), "col_r3");
        step(mk(0, 0, 0, 3'd0, 3'd0, 7'b0, 7'b1101111, 3'd4, 1, 1, 0), "col_r4");
        step(mk(0, 0, 0, 3'd0, 3'd0, 7'b0, NONE,       3'd4, 0, 0, 0), "col_end");

        // Reset during the 2nd slot of a 5-write burst.
        step(mk(0, 0, 1, 3'd0, 3'd4, 7'b0, 7'b1111110, 3'd0, 1, 0, 0), "rst_r0");
        step(mk(0, 0, 0, 3'd0, 3'd0, 7'b0, 7'b1111101, 3'd1, 1, 0, 0), "rst_r1");
        step(mk(1, 0, 0, 3'd0, 3'd0, 7'b0, NONE,       3'd0, 0, 0, 0), "rst_hit");
        step(mk(0, 0, 0, 3'd0, 3'd0, 7'b0, NONE,       3'd0, 0, 0, 0), "rst_quiet");
        step(mk(0, 0, 0, 3'd0, 3'd0, 7'b0, NONE,       3'd0, 0, 0, 0), "rst_quiet2");
        step(mk(0, 1, 0, 3'd4, 3'd0, 7'b0, 7'b1101111, 3'd4, 0, 1, 0), "rst_wr4");

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end
endmodule

// File: doc/reg_write_sequencer.md
Name: reg_write_sequencer

Overview:
- Parametrised, clocked successor of the register-file write-select decoder in the multiplier datapath.
- Converts a register index into a registered, active-low, one-hot write enable for NREGS registers.
- Adds a single-write mode and an auto-incrementing burst mode. The burst mode loads consecutive operand/partial-product registers.
- Adds per-register write protection, busy/done/error status, and a well-defined no-write code for out-of-range selects.

Parameters:
- SELECTION, 3, width of the register index.
- NREGS, 7, number of writable registers; must satisfy NREGS <= 2**SELECTION. Indices >= NREGS mean "no register".
- LENW, 3, width of the burst length field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- sSelDeco  input  SELECTION  target register index (single write) or start index (burst).
- sWrReq  input  1  single-write request, sampled at a rising edge.
- sBurstReq  input  1  burst request, sampled at a rising edge.
- sBurstLen  input  LENW  burst write count minus one (0 = 1 write).
- sProtMask  input  NREGS  bit i = 1 write-protects register i; sampled every cycle.
- sOutDeco  output  NREGS  registered write enable, active-low one-hot; all ones = no write.
- sCurSel  output  SELECTION  index associated with the current sOutDeco cycle.
- sBusy  output  1  high while a burst is emitting enables.
- sDone  output  1  one-cycle pulse coincident with the last enable cycle of any accepted request.
- sErr  output  1  one-cycle pulse flagging a rejected or suppressed write.

Behaviour:
- Reset (synchronous, active-high): on the edge where reset=1, sOutDeco <= all ones, sCurSel <= 0, sBusy <= 0, sDone <= 0, sErr <= 0, and the FSM goes to IDLE. Reset overrides every request and aborts a burst in progress; no further enables are emitted after it.
- All outputs are registered. A request sampled at edge k affects outputs from cycle k+1.
- FSM states are IDLE and BURST.
- IDLE + sBurstReq=1:
  - Start index < NREGS: load idx = sSelDeco and rem = sBurstLen; go to BURST.
  - Start index >= NREGS: stay in IDLE, sErr=1 for one cycle, no enable.
  - sBurstReq has priority over a simultaneous sWrReq; the sWrReq is dropped with no error.
- IDLE + sWrReq=1 (no sBurstReq):
  - Index < NREGS and not protected: sOutDeco bit[index]=0 for exactly one cycle, sCurSel=index, sDone=1 in that cycle, sBusy stays 0.
  - Index >= NREGS: sOutDeco stays all ones and sErr=1 for one cycle.
- BURST, once per cycle:
  - Emit the enable for idx. sCurSel=idx, sBusy=1.
  - If rem==0: sDone=1 in this cycle and return to IDLE (sBusy=0 next cycle).
  - Else: rem <= rem-1 and idx <= (idx==NREGS-1) ? 0 : idx+1. The wrap skips unused codes NREGS..2**SELECTION-1.
  - A burst of sBurstLen+1 writes occupies exactly sBurstLen+1 consecutive cycles. Bursts longer than NREGS revisit registers.
- Protection:
  - A slot whose index has sProtMask bit = 1 drives sOutDeco all ones and sErr=1 in that cycle.
  - A burst still advances and counts the protected slot.
  - sDone still pulses on the last slot, even if that slot was protected.
- Busy collisions: sWrReq or sBurstReq sampled while in BURST (including the last cycle) is ignored. sErr=1 in the following cycle, and the running burst is unaffected.
- At most one sOutDeco bit is ever low. Unused upper select codes never produce an enable.

Test Plan:
- Parameters for all scenarios: defaults (NREGS=7), sProtMask=0 unless stated.
- Single write: reset, then sWrReq=1, sSelDeco=2 for one cycle -> next cycle sOutDeco=7'b1111011, sCurSel=2, sDone=1, sBusy=0; following cycle sOutDeco=7'b1111111.
- Burst with wrap: sBurstReq=1, sSelDeco=5, sBurstLen=3 -> four consecutive cycles of sOutDeco=1011111, 0111111, 1111110, 1111101; sCurSel=5,6,0,1; sBusy=1 for those 4 cycles; sDone=1 only in the 4th.
- Protection: sProtMask=7'b0000001, burst sSelDeco=6, sBurstLen=1 -> cycle 1 sOutDeco=0111111, sErr=0; cycle 2 sOutDeco=1111111, sErr=1, sDone=1.
- Out of range: sWrReq=1, sSelDeco=7 -> next cycle sOutDeco=1111111, sErr=1, sDone=0. Same result for sBurstReq with sSelDeco=7, with sBusy staying 0.
- Collision: start burst sSelDeco=0, sBurstLen=4; pulse sBurstReq in the burst's 2nd cycle -> sErr=1 in the 3rd cycle, and the enables still run R0..R4 unchanged.
- Reset mid-burst: assert reset in the 2nd cycle of a 5-write burst -> next cycle sOutDeco=all ones, sBusy=0, sDone=0. A subsequent single write to index 4 produces 1101111.
